alu_result_checker: RTL and testbench

- Synthesizable, parametrised successor to the ALU scoreboard.
- Predicts the ALU result for each issued command and queues predictions in an expected-result FIFO, so several operations can be outstanding at once.
- Compares each DUT response in order against the queue head and maintains pass/fail statistics, sticky error flags and a first-failure capture.
- Sits beside the ALU in the testbench or an FPGA self-test wrapper, snooping the command and response buses.

---
 rtl/alu_result_checker.sv | 204 ++++++++++++++++++++
 tb/tb_alu_result_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_checker
// Purpose  : Predicts ALU results into an expected-result FIFO, checks DUT
//            responses in order, keeps pass/fail stats, sticky flags and a
//            first-mismatch capture.
// Revision : 1.0  initial release
// ============================================================================
module alu_result_checker #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         cmd_valid,
   input  logic [2:0]                   cmd_op,
   input  logic [DATA_W-1:0]            cmd_a,
   input  logic [DATA_W-1:0]            cmd_b,
   input  logic                         rsp_valid,
   input  logic [2*DATA_W-1:0]          rsp_result,
   output logic [CNT_W-1:0]             pass_count,
   output logic [CNT_W-1:0]             fail_count,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding,
   output logic                         err,
   output logic                         overflow,
   output logic                         unexpected,
   output logic                         illegal_op,
   output logic [2:0]                   fail_op,
   output logic [2*DATA_W-1:0]          fail_exp,
   output logic [2*DATA_W-1:0]          fail_got
);

   localparam int RES_W = 2 * DATA_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_RST = 3'b111;
   localparam logic [2:0] OP_I5  = 3'b101;
   localparam logic [2:0] OP_I6  = 3'b110;

   typedef struct packed {
      logic [2:0]       op;
      logic [RES_W-1:0] pred;
   } entry_t;

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d;
   logic               err_q, err_d, ovf_q, ovf_d, unexp_q, unexp_d;
   logic               ill_q, ill_d, cap_q, cap_d;
   logic [2:0]         fop_q, fop_d;
   logic [RES_W-1:0]   fexp_q, fexp_d, fgot_q, fgot_d;

   logic [RES_W-1:0]   pred;
   logic               is_arith, full, empty, pop, push, flush;
   entry_t             head;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      pred = '0;
      case (cmd_op)
         OP_ADD:  pred = RES_W'(cmd_a) + RES_W'(cmd_b);
         OP_AND:  pred = RES_W'(cmd_a & cmd_b);
         OP_XOR:  pred = RES_W'(cmd_a ^ cmd_b);
         OP_MUL:  pred = RES_W'(cmd_a) * RES_W'(cmd_b);
         default: pred = '0;
      endcase
   end

   assign head     = mem_q[rd_ptr_q];
   assign full     = (occ_q == OCC_W'(DEPTH));
   assign empty    = (occ_q == '0);
   assign is_arith = cmd_valid && (cmd_op inside {OP_ADD, OP_AND, OP_XOR, OP_MUL});
   assign flush    = cmd_valid && (cmd_op == OP_RST);
   assign pop      = rsp_valid && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push     = is_arith && (!full || pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      err_d    = err_q;
      ovf_d    = ovf_q;
      unexp_d  = unexp_q;
      ill_d    = ill_q;
      cap_d    = cap_q;
      fop_d    = fop_q;
      fexp_d   = fexp_q;
      fgot_d   = fgot_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
         pass_d   = '0;
         fail_d   = '0;
         err_d    = 1'b0;
         ovf_d    = 1'b0;
         unexp_d  = 1'b0;
         ill_d    = 1'b0;
         cap_d    = 1'b0;
         fop_d    = '0;
         fexp_d   = '0;
         fgot_d   = '0;
      end else begin
         if (rsp_valid) begin
            if (empty) begin
               if (fail_q != '1) fail_d = fail_q + 1'b1;
               err_d   = 1'b1;
               unexp_d = 1'b1;
            end else if (head.pred == rsp_result) begin
               if (pass_q != '1) pass_d = pass_q + 1'b1;
            end else begin
               if (fail_q != '1) fail_d = fail_q + 1'b1;
               err_d = 1'b1;
               if (!cap_q) begin
                  cap_d  = 1'b1;
                  fop_d  = head.op;
                  fexp_d = head.pred;
                  fgot_d = rsp_result;
               end
            end
         end
         if (is_arith && !push) ovf_d = 1'b1;
         if (cmd_valid && (cmd_op == OP_I5 || cmd_op == OP_I6)) ill_d = 1'b1;
         if (push) begin
            mem_d[wr_ptr_q] = '{op: cmd_op, pred: pred};
            wr_ptr_d        = next_ptr(wr_ptr_q);
         end
         if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
         case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
         endcase
         if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         pass_q   <= '0;
         fail_q   <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         unexp_q  <= 1'b0;
         ill_q    <= 1'b0;
         cap_q    <= 1'b0;
         fop_q    <= '0;
         fexp_q   <= '0;
         fgot_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
         unexp_q  <= unexp_d;
         ill_q    <= ill_d;
         cap_q    <= cap_d;
         fop_q    <= fop_d;
         fexp_q   <= fexp_d;
         fgot_q   <= fgot_d;
      end
   end

   assign pass_count  = pass_q;
   assign fail_count  = fail_q;
   assign outstanding = occ_q;
   assign err         = err_q;
   assign overflow    = ovf_q;
   assign unexpected  = unexp_q;
   assign illegal_op  = ill_q;
   assign fail_op     = fop_q;
   assign fail_exp    = fexp_q;
   assign fail_got    = fgot_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_checker
// Purpose  : Directed plus random check of alu_result_checker against a
//            queue-based reference model (second instance with 2-bit counters).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_checker;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, AND = 3'd2, XOR = 3'd3,
                          MUL = 3'd4, RST = 3'd7;

   logic        clk = 1'b0;
   logic        reset, clear, cmd_valid, rsp_valid;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_a, cmd_b;
   logic [15:0] rsp_result;

   logic [15:0] pass_count, fail_count, fail_exp, fail_got;
   logic [2:0]  outstanding, fail_op;
   logic        err, overflow, unexpected, illegal_op;

   logic [1:0]  pass2, fail2;
   logic [2:0]  out2, fop2;
   logic [15:0] fexp2, fgot2;
   logic        err2, ovf2, unx2, ill2;

   always #5 clk = ~clk;

   alu_result_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .clear(clear), .cmd_valid(cmd_valid),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid),
      .rsp_result(rsp_result), .pass_count(pass_count), .fail_count(fail_count),
      .outstanding(outstanding), .err(err), .overflow(overflow),
      .unexpected(unexpected), .illegal_op(illegal_op), .fail_op(fail_op),
      .fail_exp(fail_exp), .fail_got(fail_got));

   alu_result_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .clear(clear), .cmd_valid(cmd_valid),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid),
      .rsp_result(rsp_result), .pass_count(pass2), .fail_count(fail2),
      .outstanding(out2), .err(err2), .overflow(ovf2),
      .unexpected(unx2), .illegal_op(ill2), .fail_op(fop2),
      .fail_exp(fexp2), .fail_got(fgot2));

   // Reference model: plain queue of predictions and unbounded counters.
   typedef struct { logic [2:0] op; logic [15:0] pred; } ent_t;
   ent_t        m_q[$];
   int          m_pass, m_fail;
   bit          m_err, m_ovf, m_unx, m_ill, m_cap;
   logic [2:0]  m_fop;
   logic [15:0] m_fexp, m_fgot;

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_pass = 0; m_fail = 0;
      m_err = 0; m_ovf = 0; m_unx = 0; m_ill = 0; m_cap = 0;
      m_fop = '0; m_fexp = '0; m_fgot = '0;
   endfunction

   function automatic logic [15:0] predict(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int ia = int'(a);
      int ib = int'(b);
      case (op)
         ADD:     return 16'(ia + ib);
         AND:     return 16'(a & b);
         XOR:     return 16'(a ^ b);
         MUL:     return 16'(ia * ib);
         default: return 16'h0;
      endcase
   endfunction

   function automatic void model_step(input bit cv, input logic [2:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input bit rv, input logic [15:0] res,
                                      input bit clr);
      ent_t e;
      if (clr) begin
         model_reset();
         return;
      end
      if (rv) begin
         if (m_q.size() == 0) begin
            m_fail++; m_err = 1; m_unx = 1;
         end else begin
            e = m_q.pop_front();
            if (e.pred == res) m_pass++;
            else begin
               m_fail++; m_err = 1;
               if (!m_cap) begin
                  m_cap = 1; m_fop = e.op; m_fexp = e.pred; m_fgot = res;
               end
            end
         end
      end
      if (cv) begin
         if (op == RST) m_q.delete();
         else if (op == 3'd5 || op == 3'd6) m_ill = 1;
         else if (op != NOP) begin
            if (m_q.size() < DEPTH) begin
               e.op = op; e.pred = predict(op, a, b);
               m_q.push_back(e);
            end else m_ovf = 1;
         end
      end
   endfunction

   function automatic logic [15:0] head_pred();
      return (m_q.size() > 0) ? m_q[0].pred : 16'h0;
   endfunction

   task automatic check_all(input string tag);
      check_val({tag, ".pass"}, 32'(pass_count), 32'(m_pass));
      check_val({tag, ".fail"}, 32'(fail_count), 32'(m_fail));
      check_val({tag, ".outst"}, 32'(outstanding), 32'(m_q.size()));
      check_val({tag, ".flags"}, {28'd0, err, overflow, unexpected, illegal_op},
                {28'd0, m_err, m_ovf, m_unx, m_ill});
      check_val({tag, ".fop"}, 32'(fail_op), 32'(m_fop));
      check_val({tag, ".fexp"}, 32'(fail_exp), 32'(m_fexp));
      check_val({tag, ".fgot"}, 32'(fail_got), 32'(m_fgot));
      check_val({tag, ".pass_sat"}, 32'(pass2), 32'(m_pass > 3 ? 3 : m_pass));
      check_val({tag, ".fail_sat"}, 32'(fail2), 32'(m_fail > 3 ? 3 : m_fail));
   endtask

   task automatic cyc(input string tag, input bit cv, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input bit rv, input logic [15:0] res, input bit clr = 0);
      cmd_valid = cv; cmd_op = op; cmd_a = a; cmd_b = b;
      rsp_valid = rv; rsp_result = res; clear = clr;
      @(posedge clk);
      model_step(cv, op, a, b, rv, res, clr);
      #1;
      cmd_valid = 0; rsp_valid = 0; clear = 0;
      check_all(tag);
   endtask

   initial begin
      reset = 1; clear = 0; cmd_valid = 0; rsp_valid = 0;
      cmd_op = NOP; cmd_a = 0; cmd_b = 0; rsp_result = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset = 0;

      cyc("t1_cmd", 1, ADD, 8'hFF, 8'h01, 0, 0);
      cyc("t1_rsp", 0, NOP, 0, 0, 1, 16'h0100);
      check_val("t1_pass_const", 32'(pass_count), 32'd1);

      cyc("t2_cmd", 1, MUL, 8'hFF, 8'hFF, 0, 0);
      cyc("t2_rsp", 0, NOP, 0, 0, 1, 16'hFE00);
      check_val("t2_fexp_const", 32'(fail_exp), 32'hFE01);
      cyc("t2_cmd2", 1, XOR, 8'h0F, 8'hF0, 0, 0);
      cyc("t2_rsp2", 0, NOP, 0, 0, 1, 16'h0000);
      check_val("t2_fail_const", 32'(fail_count), 32'd2);

      cyc("t3_clr", 0, NOP, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc("t3_fill", 1, ADD, 8'(i), 8'(i + 1), 0, 0);
      check_val("t3_ovf_const", 32'(overflow), 32'd1);
      for (int i = 0; i < 4; i++) cyc("t3_drain", 0, NOP, 0, 0, 1, head_pred());
      cyc("t3_unexp", 0, NOP, 0, 0, 1, 16'h1234);
      check_val("t3_unx_const", 32'(unexpected), 32'd1);

      cyc("t4_clr", 0, NOP, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc("t4_and", 1, AND, 8'hA5, 8'(i), 0, 0);
      cyc("t4_rstop", 1, RST, 0, 0, 0, 0);
      cyc("t4_nop", 1, NOP, 0, 0, 0, 0);
      cyc("t4_ill", 1, 3'd5, 0, 0, 0, 0);
      check_val("t4_ill_const", 32'(illegal_op), 32'd1);

      cyc("t5_clr", 0, NOP, 0, 0, 0, 0, 1);
      cyc("t5_add1", 1, ADD, 8'h01, 8'h01, 0, 0);
      cyc("t5_same", 1, ADD, 8'h02, 8'h03, 1, 16'h0002);
      cyc("t5_rsp2", 0, NOP, 0, 0, 1, 16'h0005);
      check_val("t5_pass_const", 32'(pass_count), 32'd2);

      cyc("t6_clr", 0, NOP, 0, 0, 0, 0, 1);
      cyc("t6_a", 1, ADD, 8'h10, 8'h20, 0, 0);
      cyc("t6_b", 1, MUL, 8'h03, 8'h04, 0, 0);
      #2 reset = 1;
      model_reset();
      #1 check_all("t6_async");
      #2 reset = 0;
      @(posedge clk); #1;
      cyc("t6_clr2", 0, NOP, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         cyc("t6_sat_cmd", 1, ADD, 8'(i), 8'h07, 0, 0);
         cyc("t6_sat_rsp", 0, NOP, 0, 0, 1, head_pred());
      end
      check_val("t6_sat_const", 32'(pass2), 32'd3);

      for (int i = 0; i < 600; i++) begin
         bit          cv, rv, clr;
         logic [2:0]  op;
         logic [15:0] res;
         cv  = ($urandom_range(0, 9) < 7);
         op  = 3'($urandom_range(0, 7));
         rv  = ($urandom_range(0, 1) == 1);
         clr = ($urandom_range(0, 49) == 0);
         res = head_pred();
         if ($urandom_range(0, 4) == 0) res = res ^ (16'h1 << $urandom_range(0, 15));
         cyc("rnd", cv, op, 8'($urandom), 8'($urandom), rv, res, clr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
